// File: rtl/multi_sync_rx_pkg.sv
// Shared definitions for the multi-channel toggle-handshake receiver.
// Holds the default sizing parameters and the channel-index width helper
// used by the interface, the top level and the testbench.
package multi_sync_rx_pkg;

  localparam int MSR_DATA_WIDTH  = 8;
  localparam int MSR_CHANNELS    = 4;
  localparam int MSR_SYNC_STAGES = 2;

  // Channel index width. A single channel still gets a 1-bit index
  // so that dout_ch never becomes a zero-width vector.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_sync_rx_if.sv
// Bundle of the receiver's channel-side and stream-side signals.
//   req_tgl   source -> rx   per-channel request toggles (asynchronous)
//   din       source -> rx   channel c at din[c*DATA_WIDTH +: DATA_WIDTH]
//   ack_tgl   rx -> source   per-channel acknowledge toggles
//   dout      rx -> sink     output word
//   dout_ch   rx -> sink     channel that produced dout
//   valid_out rx -> sink     dout/dout_ch valid
//   ready_in  sink -> rx     sink accepts on valid_out && ready_in
//   overrun   rx -> sink     sticky per-channel protocol-error flags
// slave is the receiver's view; master is the environment's view.
interface multi_sync_rx_if
  import multi_sync_rx_pkg::*;
#(
  parameter int DATA_WIDTH = MSR_DATA_WIDTH,
  parameter int CHANNELS   = MSR_CHANNELS
);
  localparam int CH_W = clog2_min1(CHANNELS);

  logic [CHANNELS-1:0]            req_tgl;
  logic [CHANNELS*DATA_WIDTH-1:0] din;
  logic [CHANNELS-1:0]            ack_tgl;
  logic [DATA_WIDTH-1:0]          dout;
  logic [CH_W-1:0]                dout_ch;
  logic                           valid_out;
  logic                           ready_in;
  logic [CHANNELS-1:0]            overrun;

  modport slave (
    input  req_tgl, din, ready_in,
    output ack_tgl, dout, dout_ch, valid_out, overrun
  );

  modport master (
    output req_tgl, din, ready_in,
    input  ack_tgl, dout, dout_ch, valid_out, overrun
  );

endinterface

// File: rtl/multi_sync_rx_tgl_sync_edge.sv
// tgl_sync_edge: brings one asynchronous request-toggle line into the clk
// domain through a SYNC_STAGES flop chain, then compares the synchronised
// level with a one-cycle delayed copy to produce a single-cycle pulse for
// every toggle of the source line.
//   clk       local clock
//   rst       asynchronous active-high reset
//   req_tgl   asynchronous toggle input
//   edge_det  one-cycle pulse per toggle, synchronous to clk
module tgl_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_tgl,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] s_reg;
  logic                   s_d_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg   <= '0;
      s_d_reg <= 1'b0;
    end else begin
      s_reg   <= {s_reg[SYNC_STAGES-2:0], req_tgl};
      s_d_reg <= s_reg[SYNC_STAGES-1];
    end
  end

  assign edge_det = s_reg[SYNC_STAGES-1] ^ s_d_reg;

endmodule

// File: rtl/multi_sync_rx.sv
// multi_sync_rx: destination-side receiver for CHANNELS independent toggle
// req/ack transfers. Each channel's request is synchronised, the held source
// word is captured on the detected toggle, and pending words from all
// channels are merged round-robin onto a single ready/valid stream. The ack
// toggle for a word is issued when it is loaded into the output register.
//   clk  local clock (every flop)
//   rst  asynchronous active-high reset
//   bus  multi_sync_rx_if.slave: req_tgl/din in, ack_tgl out,
//        dout/dout_ch/valid_out out, ready_in in, overrun out
module multi_sync_rx
  import multi_sync_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = MSR_DATA_WIDTH,
  parameter int CHANNELS    = MSR_CHANNELS,
  parameter int SYNC_STAGES = MSR_SYNC_STAGES
) (
  input  logic           clk,
  input  logic           rst,
  multi_sync_rx_if.slave bus
);

  localparam int CH_W = clog2_min1(CHANNELS);

  logic [CHANNELS-1:0]   edge_det;
  logic [DATA_WIDTH-1:0] hold_reg [CHANNELS];
  logic [CHANNELS-1:0]   pend_reg;
  logic [CHANNELS-1:0]   ack_reg;
  logic [CHANNELS-1:0]   overrun_reg;
  logic [DATA_WIDTH-1:0] dout_reg;
  logic [CH_W-1:0]       dout_ch_reg;
  logic                  valid_reg;
  logic [CH_W-1:0]       ptr_reg;

  logic                  out_free;
  logic                  grant_any;
  logic [CH_W-1:0]       grant_idx;
  logic [CH_W-1:0]       ptr_next;
  logic [CHANNELS-1:0]   grant_vec;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_sync
      tgl_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .req_tgl  (bus.req_tgl[gi]),
        .edge_det (edge_det[gi])
      );
    end
  endgenerate

  // The output register can take a new word when it is empty or when its
  // current word is being accepted on this edge.
  assign out_free = !valid_reg || bus.ready_in;

  // Round-robin search: first pending channel at or after the pointer,
  // wrapping around. grant_vec is only set when the grant really happens.
  always_comb begin
    int              cand;
    logic [CH_W-1:0] cand_idx;
    grant_any = 1'b0;
    grant_idx = '0;
    ptr_next  = ptr_reg;
    grant_vec = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand     = (int'(ptr_reg) + i) % CHANNELS;
      cand_idx = CH_W'(cand);
      if (!grant_any && pend_reg[cand_idx]) begin
        grant_any           = 1'b1;
        grant_idx           = cand_idx;
        ptr_next            = CH_W'((cand + 1) % CHANNELS);
        grant_vec[cand_idx] = out_free;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        hold_reg[c] <= '0;
      end
      pend_reg    <= '0;
      ack_reg     <= '0;
      overrun_reg <= '0;
      dout_reg    <= '0;
      dout_ch_reg <= '0;
      valid_reg   <= 1'b0;
      ptr_reg     <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (edge_det[c]) begin
          hold_reg[c] <= bus.din[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      // A capture on the same cycle as its channel's grant keeps the new
      // word pending; the grant itself reads the old hold value.
      pend_reg    <= (pend_reg & ~grant_vec) | edge_det;
      // A new toggle while the previous word is still unconsumed means the
      // source did not wait for its ack.
      overrun_reg <= overrun_reg | (edge_det & pend_reg);
      ack_reg     <= ack_reg ^ grant_vec;
      if (out_free) begin
        valid_reg <= grant_any;
        if (grant_any) begin
          dout_reg    <= hold_reg[grant_idx];
          dout_ch_reg <= grant_idx;
          ptr_reg     <= ptr_next;
        end
      end
    end
  end

  assign bus.ack_tgl   = ack_reg;
  assign bus.dout      = dout_reg;
  assign bus.dout_ch   = dout_ch_reg;
  assign bus.valid_out = valid_reg;
  assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_multi_sync_rx.sv
// Self-checking bench for multi_sync_rx: directed scenarios plus a
// randomized multi-channel back-to-back run checked against per-channel
// expected-word queues.
module tb_multi_sync_rx;
  import multi_sync_rx_pkg::*;

  localparam int DW = 8;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int CW = clog2_min1(CH);
  localparam int NW = 16;

  logic clk     = 1'b0;
  logic src_clk = 1'b0;
  logic rst     = 1'b0;

  always #9 clk = ~clk;
  initial begin
    #3;
    forever #10 src_clk = ~src_clk;
  end

  multi_sync_rx_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

  multi_sync_rx #(
    .DATA_WIDTH  (DW),
    .CHANNELS    (CH),
    .SYNC_STAGES (SS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    logic [CH-1:0] ack;
    int            cyc;
  } rec_t;

  rec_t          log_q [$];
  logic [DW-1:0] exp_q [CH][$];
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted word; the transfer completes on the next posedge.
  always @(negedge clk) begin
    if (bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
      log_q.push_back('{ch: int'(bus.dout_ch), data: bus.dout, ack: bus.ack_tgl, cyc: cyc});
      $display("[%0t] accept ch=%0d data=%02h ack=%b", $time, bus.dout_ch, bus.dout, bus.ack_tgl);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Round-robin reference: first pending channel at or after ptr.
  function automatic int rr_pick(input logic [CH-1:0] pend, input int ptr);
    for (int i = 0; i < CH; i++) begin
      if (pend[(ptr + i) % CH]) return (ptr + i) % CH;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int c, input logic [DW-1:0] d);
    bus.din[c*DW +: DW] = d;
    bus.req_tgl[c]      = ~bus.req_tgl[c];
  endtask

  task automatic wait_log(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      if (log_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      if (bus.valid_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.req_tgl  = '0;
    bus.din      = '0;
    bus.ready_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic test_reset();
    bus.req_tgl  = '0;
    bus.din      = '0;
    bus.ready_in = 1'b0;
    #1 rst = 1'b1;
    #4;  // still before the first clk edge: reset must act asynchronously
    n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b want=0", bus.valid_out); end
    n_checks++; if (bus.dout !== 8'h00) begin n_fail++; $display("FAIL rst_dout got=%h want=00", bus.dout); end
    n_checks++; if (bus.dout_ch !== 2'd0) begin n_fail++; $display("FAIL rst_dout_ch got=%0d want=0", bus.dout_ch); end
    n_checks++; if (bus.ack_tgl !== 4'b0000) begin n_fail++; $display("FAIL rst_ack got=%b want=0000", bus.ack_tgl); end
    n_checks++; if (bus.overrun !== 4'b0000) begin n_fail++; $display("FAIL rst_overrun got=%b want=0000", bus.overrun); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_idle_valid got=%b want=0", bus.valid_out); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    tick();
    bus.ready_in = 1'b1;
    send(0, 8'h01);
    wait_log(1, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL single_timeout got=no word want=1 word");
    end else begin
      n_checks++; if (log_q[0].ch !== 0 || log_q[0].data !== 8'h01)
        begin n_fail++; $display("FAIL single_word got=ch%0d/%h want=ch0/01", log_q[0].ch, log_q[0].data); end
      n_checks++; if (log_q[0].ack[0] !== 1'b1)
        begin n_fail++; $display("FAIL single_ack1 got=%b want=1", log_q[0].ack[0]); end
      @(negedge clk); #1;
      n_checks++; if (bus.valid_out !== 1'b0)
        begin n_fail++; $display("FAIL single_one_cycle got=%b want=0", bus.valid_out); end
    end
    tick();
    send(0, 8'h02);
    wait_log(2, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL single2_timeout got=%0d words want=2", log_q.size());
    end else begin
      n_checks++; if (log_q[1].data !== 8'h02 || log_q[1].ack[0] !== 1'b0)
        begin n_fail++; $display("FAIL single2 got=%h ack=%b want=02 ack=0", log_q[1].data, log_q[1].ack[0]); end
    end
    $display("test_single done");
  endtask

  task automatic test_contention();
    bit            ok;
    logic [CH-1:0] pend;
    int            ptr;
    int            g;
    do_reset();
    tick();
    bus.ready_in = 1'b1;
    for (int c = 1; c < CH; c++) send(c, 8'hA0 + 8'(c));
    wait_log(3, 30, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL contention_timeout got=%0d words want=3", log_q.size());
    end else begin
      pend = 4'b1110;
      ptr  = 0;
      for (int i = 0; i < 3; i++) begin
        g    = rr_pick(pend, ptr);
        pend[g] = 1'b0;
        ptr  = (g + 1) % CH;
        n_checks++; if (log_q[i].ch !== g)
          begin n_fail++; $display("FAIL contention_ch%0d got=%0d want=%0d", i, log_q[i].ch, g); end
        n_checks++; if (log_q[i].data !== 8'hA0 + 8'(g))
          begin n_fail++; $display("FAIL contention_data%0d got=%h want=%h", i, log_q[i].data, 8'hA0 + 8'(g)); end
        n_checks++; if (log_q[i].cyc !== log_q[0].cyc + i)
          begin n_fail++; $display("FAIL contention_rate%0d got=cyc%0d want=cyc%0d", i, log_q[i].cyc, log_q[0].cyc + i); end
      end
      @(negedge clk); #1;
      n_checks++; if (bus.valid_out !== 1'b0)
        begin n_fail++; $display("FAIL contention_drain got=%b want=0", bus.valid_out); end
    end
    $display("test_contention done");
  endtask

  task automatic test_backpressure();
    bit   ok;
    logic ack_hold;
    do_reset();
    tick();
    send(0, 8'h55);
    wait_valid(20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL bp_timeout got=no valid want=valid");
    end else begin
      ack_hold = bus.ack_tgl[0];
      n_checks++; if (ack_hold !== 1'b1)
        begin n_fail++; $display("FAIL bp_ack_on_load got=%b want=1", ack_hold); end
      for (int i = 0; i < 10; i++) begin
        @(negedge clk); #1;
        n_checks++;
        if ({bus.valid_out, bus.dout, bus.dout_ch, bus.ack_tgl[0]} !== {1'b1, 8'h55, 2'd0, ack_hold}) begin
          n_fail++;
          $display("FAIL bp_stall%0d got=v%b %h ch%0d a%b want=v1 55 ch0 a%b", i,
                   bus.valid_out, bus.dout, bus.dout_ch, bus.ack_tgl[0], ack_hold);
        end
      end
      tick();
      bus.ready_in = 1'b1;
      wait_log(1, 5, ok);
      n_checks++; if (!ok || log_q[0].data !== 8'h55)
        begin n_fail++; $display("FAIL bp_accept got=%0d words want=1 word 55", log_q.size()); end
      n_checks++; if (bus.ack_tgl[0] !== ack_hold)
        begin n_fail++; $display("FAIL bp_ack_after got=%b want=%b", bus.ack_tgl[0], ack_hold); end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    tick();
    send(0, 8'h33);           // occupy the output register while stalled
    wait_valid(20, ok);
    tick();
    send(2, 8'h10);
    repeat (6) tick();
    send(2, 8'h20);           // second toggle before 0x10 was consumed
    repeat (6) tick();
    n_checks++; if (bus.overrun !== 4'b0100)
      begin n_fail++; $display("FAIL overrun_flag got=%b want=0100", bus.overrun); end
    bus.ready_in = 1'b1;
    wait_log(2, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL overrun_timeout got=%0d words want=2", log_q.size());
    end else begin
      n_checks++; if (log_q[0].ch !== 0 || log_q[0].data !== 8'h33)
        begin n_fail++; $display("FAIL overrun_first got=ch%0d/%h want=ch0/33", log_q[0].ch, log_q[0].data); end
      n_checks++; if (log_q[1].ch !== 2 || log_q[1].data !== 8'h20)
        begin n_fail++; $display("FAIL overrun_word got=ch%0d/%h want=ch2/20", log_q[1].ch, log_q[1].data); end
    end
    tick();
    send(1, 8'h77);
    wait_log(3, 20, ok);
    repeat (3) tick();
    n_checks++; if (bus.overrun !== 4'b0100)
      begin n_fail++; $display("FAIL overrun_sticky got=%b want=0100", bus.overrun); end
    $display("test_overrun done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    tick();
    send(0, 8'h11);
    wait_valid(20, ok);
    tick();
    send(1, 8'h22);
    send(3, 8'h33);
    repeat (5) tick();
    n_checks++; if (bus.valid_out !== 1'b1)
      begin n_fail++; $display("FAIL rmid_pre got=%b want=1", bus.valid_out); end
    @(posedge clk);
    #4;
    rst          = 1'b1;
    bus.req_tgl  = '0;
    bus.din      = '0;
    #1;
    n_checks++;
    if ({bus.valid_out, bus.dout, bus.dout_ch, bus.ack_tgl, bus.overrun} !== '0) begin
      n_fail++;
      $display("FAIL rmid_async got=v%b %h ch%0d a%b o%b want=all 0",
               bus.valid_out, bus.dout, bus.dout_ch, bus.ack_tgl, bus.overrun);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    bus.ready_in = 1'b1;
    repeat (12) tick();
    n_checks++; if (log_q.size() !== 0 || bus.valid_out !== 1'b0)
      begin n_fail++; $display("FAIL rmid_spurious got=%0d words want=0", log_q.size()); end
    n_checks++; if (bus.ack_tgl !== 4'b0000)
      begin n_fail++; $display("FAIL rmid_ack got=%b want=0000", bus.ack_tgl); end
    $display("test_reset_mid done");
  endtask

  task automatic sender(input int c);
    int            guard;
    logic [DW-1:0] w;
    for (int k = 0; k <= NW; k++) begin
      @(posedge src_clk);
      guard = 0;
      while (bus.ack_tgl[c] !== bus.req_tgl[c] && guard < 200) begin
        @(posedge src_clk);
        guard++;
      end
      n_checks++;
      if (guard >= 200) begin
        n_fail++;
        $display("FAIL b2b_ack_timeout ch%0d got=ack%b want=ack%b", c, bus.ack_tgl[c], bus.req_tgl[c]);
        return;
      end
      if (k == NW) return;  // last pass only waits for the final ack
      w = 8'($urandom);
      exp_q[c].push_back(w);
      send(c, w);
      repeat ($urandom_range(0, 1)) @(posedge src_clk);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit done;
    int ch;
    do_reset();
    for (int c = 0; c < CH; c++) exp_q[c].delete();
    done = 1'b0;
    fork
      begin
        fork
          sender(0);
          sender(1);
          sender(2);
          sender(3);
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          bus.ready_in = ($urandom_range(0, 3) != 0);
        end
      end
    join
    tick();
    bus.ready_in = 1'b1;
    wait_log(CH * NW, 50, ok);
    n_checks++; if (!ok)
      begin n_fail++; $display("FAIL b2b_count got=%0d want=%0d", log_q.size(), CH * NW); end
    foreach (log_q[i]) begin
      ch = log_q[i].ch;
      n_checks++;
      if (ch < 0 || ch >= CH || exp_q[ch].size() == 0) begin
        n_fail++; $display("FAIL b2b_extra got=ch%0d/%h want=no word", ch, log_q[i].data);
      end else if (log_q[i].data !== exp_q[ch][0]) begin
        n_fail++; $display("FAIL b2b_order ch%0d got=%h want=%h", ch, log_q[i].data, exp_q[ch][0]);
        void'(exp_q[ch].pop_front());
      end else begin
        void'(exp_q[ch].pop_front());
      end
    end
    for (int c = 0; c < CH; c++) begin
      n_checks++; if (exp_q[c].size() != 0)
        begin n_fail++; $display("FAIL b2b_lost ch%0d got=%0d left want=0", c, exp_q[c].size()); end
    end
    n_checks++; if (bus.overrun !== 4'b0000)
      begin n_fail++; $display("FAIL b2b_overrun got=%b want=0000", bus.overrun); end
    n_checks++; if (bus.ack_tgl !== bus.req_tgl)
      begin n_fail++; $display("FAIL b2b_handshake got=ack%b want=req%b", bus.ack_tgl, bus.req_tgl); end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
